risc_v_id_stage: RTL and testbench
==================================

Name: risc_v_id_stage

Overview:
- Registered, parametrised RV32I instruction-decode pipeline stage, with optional M-extension decode.
- Sits between fetch and execute, with valid/ready handshakes on both sides.
- Contains a 2-entry buffer (output register plus skid register), so in_ready never depends combinationally on out_ready.
- Produces a one-hot instruction vector, the correctly formatted immediate, register indices, the PC, and an illegal-instruction flag.

Parameters:
XLEN, 32, datapath width (32 or 64); width of pc and immediate. Instruction is always 32 bits; only RV32 encodings are decoded.
EN_M, 0, 1 = also decode the 8 RV32M instructions.
DEC_W, 37+8*EN_M, derived width of inst_decode; not overridable.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard all buffered entries (branch redirect / trap)
in_valid  input  1  fetch presents inst/pc_i
in_ready  output  1  stage can accept an entry this cycle
inst  input  32  instruction word
pc_i  input  XLEN  PC of inst
out_valid  output  1  decoded entry available
out_ready  input  1  execute accepts the entry
pc_o  output  XLEN  PC of the decoded entry
inst_decode  output  DEC_W  one-hot instruction identity
imm_out  output  XLEN  immediate, sign-extended, already shifted
rd1  output  5  inst[19:15]
rd2  output  5  inst[24:20]
wr  output  5  inst[11:7]
illegal  output  1  entry matched no decoded instruction

Behaviour:
- Reset is asynchronous and active-high; rst asserted at any time, including mid-stall, clears state immediately:
  - both valids 0; all output data 0; in_ready 1.
- Decode is combinational on inst and captured with the entry; outputs are driven only from registers.
- inst_decode bit order (LSB first):
  - 0 auipc, 1 lui, 2 jal, 3 jalr
  - 4 beq, 5 bne, 6 blt, 7 bge, 8 bltu, 9 bgeu
  - 10 lb, 11 lh, 12 lw, 13 lbu, 14 lhu
  - 15 sb, 16 sh, 17 sw
  - 18 addi, 19 slti, 20 sltiu, 21 xori, 22 ori, 23 andi
  - 24 slli, 25 srli, 26 srai
  - 27 add, 28 sub, 29 sll, 30 slt, 31 sltu, 32 xor, 33 srl, 34 sra, 35 or, 36 and
  - EN_M=1 only: 37 mul, 38 mulh, 39 mulhsu, 40 mulhu, 41 div, 42 divu, 43 rem, 44 remu (opcode 0110011, func7 0000001).
- Matching rules:
  - Shift-immediates require inst[31:25]=0000000 (srai: 0100000).
  - R-type requires the exact func7.
  - inst[1:0] != 2'b11 never matches.
- illegal=1 iff no decode bit is set; then inst_decode=0 and imm_out=0. FENCE and SYSTEM are illegal (handled by the trap unit).
- imm_out selection, all sign-extended from inst[31] to XLEN:
  - I-format: loads, jalr, and the ALU-immediate ops except shifts.
  - Shifts: zero-extended inst[24:20].
  - S-format: all stores.
  - B-format, with bit0=0: branches.
  - U-format, {inst[31:12],12'h0}: lui, auipc.
  - J-format, with bit0=0: jal.
  - R-type: 0.
- Handshake:
  - Accept on in_valid&in_ready; deliver on out_valid&out_ready.
  - Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
- Buffer states: EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (both occupied). in_ready = !skid_valid, i.e. 0 only in FULL.
  - EMPTY + accept -> ONE.
  - ONE + accept, no deliver -> FULL (new entry into skid).
  - ONE + accept + deliver -> ONE (new entry into output register).
  - ONE + deliver only -> EMPTY.
  - FULL + deliver -> ONE (skid moves to output register); no accept in FULL.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Output data are held stable while out_valid=1 and out_ready=0.
- flush: at the next edge both valids go to 0 and in_ready goes to 1. An input presented in the flush cycle is dropped even if in_ready=1. flush has priority over accept and deliver.
- Data registers load only on capture; they are not cleared on flush.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), pc 0x100, out_ready=1 -> next cycle: out_valid=1, bit18 set, imm_out=0xFFFFFFFF, wr=1, rd1=0, pc_o=0x100, illegal=0.
- Sequence beq x1,x2,-4 (0xFE208EE3) then jalr x1,8(x2) (0x008100E7) -> bit4 with imm 0xFFFFFFFC, then bit3 with imm 0x00000008, rd1=2; both in consecutive cycles with no bubble.
- mul x3,x1,x2 (0x022081B3):
  - EN_M=1 -> bit37 set, imm 0, wr=3.
  - EN_M=0 -> illegal=1, inst_decode=0.
  - Also 0x0000000F (fence) -> illegal=1.
- out_ready=0, feed I0,I1,I2 back-to-back -> in_ready falls after I1 is accepted and I2 is held by fetch; raise out_ready -> I0,I1,I2 emerge in order, one per cycle, with outputs stable during the stall.
- FULL state, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed/presented entries never appear.
- Assert rst asynchronously mid-stall in FULL -> immediately out_valid=0, outputs 0, in_ready=1.

Source files
------------

// File: rtl/risc_v_id_stage.sv
// RV32I (+ optional RV32M) decode stage with a two-entry output/skid buffer.
// Outputs come only from registers; in_ready depends only on buffer state.
module risc_v_id_stage #(
   parameter int XLEN = 32,
   parameter int EN_M = 0,
   localparam int DEC_W = 37 + 8*EN_M
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  pc_o,
   output logic [DEC_W-1:0] inst_decode,
   output logic [XLEN-1:0]  imm_out,
   output logic [4:0]       rd1,
   output logic [4:0]       rd2,
   output logic [4:0]       wr,
   output logic             illegal
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [DEC_W-1:0] dec;
      logic [XLEN-1:0]  imm;
      logic [4:0]       rd1;
      logic [4:0]       rd2;
      logic [4:0]       wr;
      logic             ill;
   } ent_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   logic [6:0]       opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [36:0]      dec_b;
   logic [DEC_W-1:0] dec;
   logic [XLEN-1:0]  imm_d;
   logic             is_u, is_j, is_i, is_sh, is_s, is_b;
   ent_t             ent_d, out_q, skid_q;
   state_t           state_q, state_d;
   logic             ld_out, ld_skid, sel_skid;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];

   // Full 7-bit opcode match also rejects inst[1:0] != 2'b11.
   always_comb begin
      dec_b = '0;
      unique case (opc)
         7'b0010111: dec_b[0] = 1'b1;
         7'b0110111: dec_b[1] = 1'b1;
         7'b1101111: dec_b[2] = 1'b1;
         7'b1100111: dec_b[3] = (f3 == 3'd0);
         7'b1100011: begin
            dec_b[4] = (f3 == 3'd0);
            dec_b[5] = (f3 == 3'd1);
            dec_b[6] = (f3 == 3'd4);
            dec_b[7] = (f3 == 3'd5);
            dec_b[8] = (f3 == 3'd6);
            dec_b[9] = (f3 == 3'd7);
         end
         7'b0000011: begin
            dec_b[10] = (f3 == 3'd0);
            dec_b[11] = (f3 == 3'd1);
            dec_b[12] = (f3 == 3'd2);
            dec_b[13] = (f3 == 3'd4);
            dec_b[14] = (f3 == 3'd5);
         end
         7'b0100011: begin
            dec_b[15] = (f3 == 3'd0);
            dec_b[16] = (f3 == 3'd1);
            dec_b[17] = (f3 == 3'd2);
         end
         7'b0010011: begin
            dec_b[18] = (f3 == 3'd0);
            dec_b[19] = (f3 == 3'd2);
            dec_b[20] = (f3 == 3'd3);
            dec_b[21] = (f3 == 3'd4);
            dec_b[22] = (f3 == 3'd6);
            dec_b[23] = (f3 == 3'd7);
            dec_b[24] = (f3 == 3'd1) && (f7 == 7'h00);
            dec_b[25] = (f3 == 3'd5) && (f7 == 7'h00);
            dec_b[26] = (f3 == 3'd5) && (f7 == 7'h20);
         end
         7'b0110011: begin
            dec_b[27] = (f7 == 7'h00) && (f3 == 3'd0);
            dec_b[28] = (f7 == 7'h20) && (f3 == 3'd0);
            dec_b[29] = (f7 == 7'h00) && (f3 == 3'd1);
            dec_b[30] = (f7 == 7'h00) && (f3 == 3'd2);
            dec_b[31] = (f7 == 7'h00) && (f3 == 3'd3);
            dec_b[32] = (f7 == 7'h00) && (f3 == 3'd4);
            dec_b[33] = (f7 == 7'h00) && (f3 == 3'd5);
            dec_b[34] = (f7 == 7'h20) && (f3 == 3'd5);
            dec_b[35] = (f7 == 7'h00) && (f3 == 3'd6);
            dec_b[36] = (f7 == 7'h00) && (f3 == 3'd7);
         end
         default: ;
      endcase
   end

   if (EN_M != 0) begin : g_m
      logic [7:0] dec_m;
      always_comb begin
         dec_m = '0;
         if (opc == 7'b0110011 && f7 == 7'h01)
            dec_m[f3] = 1'b1;
      end
      assign dec = {dec_m, dec_b};
   end else begin : g_nm
      assign dec = dec_b;
   end

   assign is_u  = |dec_b[1:0];
   assign is_j  = dec_b[2];
   assign is_i  = dec_b[3] | (|dec_b[14:10]) | (|dec_b[23:18]);
   assign is_b  = |dec_b[9:4];
   assign is_s  = |dec_b[17:15];
   assign is_sh = |dec_b[26:24];

   always_comb begin
      imm_d = '0;
      unique case (1'b1)
         is_u:  imm_d = XLEN'($signed({inst[31:12], 12'h000}));
         is_j:  imm_d = XLEN'($signed({inst[31], inst[19:12],
                                       inst[20], inst[30:21], 1'b0}));
         is_i:  imm_d = XLEN'($signed(inst[31:20]));
         is_sh: imm_d = XLEN'(inst[24:20]);
         is_s:  imm_d = XLEN'($signed({inst[31:25], inst[11:7]}));
         is_b:  imm_d = XLEN'($signed({inst[31], inst[7],
                                       inst[30:25], inst[11:8], 1'b0}));
         default: imm_d = '0;
      endcase
   end

   assign ent_d = '{pc:  pc_i,
                    dec: dec,
                    imm: imm_d,
                    rd1: inst[19:15],
                    rd2: inst[24:20],
                    wr:  inst[11:7],
                    ill: ~|dec};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) state_d = EMPTY;
      else begin
         unique case (state_q)
            EMPTY: if (in_valid) state_d = ONE;
            ONE: begin
               if (in_valid && !out_ready)      state_d = FULL;
               else if (!in_valid && out_ready) state_d = EMPTY;
            end
            FULL: if (out_ready) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      ld_out   = 1'b0;
      ld_skid  = 1'b0;
      sel_skid = 1'b0;
      if (!flush) begin
         unique case (state_q)
            EMPTY: ld_out = in_valid;
            ONE: begin
               ld_out  = in_valid & out_ready;
               ld_skid = in_valid & ~out_ready;
            end
            FULL: begin
               ld_out   = out_ready;
               sel_skid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Data only moves on capture; flush just drops the valids.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (ld_out)  out_q  <= sel_skid ? skid_q : ent_d;
         if (ld_skid) skid_q <= ent_d;
      end
   end

   assign out_valid   = (state_q != EMPTY);
   assign in_ready    = (state_q != FULL);
   assign pc_o        = out_q.pc;
   assign inst_decode = out_q.dec;
   assign imm_out     = out_q.imm;
   assign rd1         = out_q.rd1;
   assign rd2         = out_q.rd2;
   assign wr          = out_q.wr;
   assign illegal     = out_q.ill;

endmodule

// File: tb/tb_risc_v_id_stage.sv
// Bench for risc_v_id_stage: EN_M=0 and EN_M=1 instances share stimulus
// and are compared with a mask/match decode table and a FIFO model.
module tb_risc_v_id_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] inst, pc_i;

   logic        ov0, ir0, il0, ov1, ir1, il1;
   logic [31:0] pc0, imm0, pc1, imm1;
   logic [36:0] dec0;
   logic [44:0] dec1;
   logic [4:0]  r1_0, r2_0, w0, r1_1, r2_1, w1;

   int errs = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;
   ent_t q[$];

   localparam logic [31:0] MT [45] = '{
      32'h00000017, 32'h00000037, 32'h0000006F, 32'h00000067,
      32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063,
      32'h00006063, 32'h00007063,
      32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003,
      32'h00005003,
      32'h00000023, 32'h00001023, 32'h00002023,
      32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013,
      32'h00006013, 32'h00007013,
      32'h00001013, 32'h00005013, 32'h40005013,
      32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033,
      32'h00003033, 32'h00004033, 32'h00005033, 32'h40005033,
      32'h00006033, 32'h00007033,
      32'h02000033, 32'h02001033, 32'h02002033, 32'h02003033,
      32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033};

   risc_v_id_stage #(.XLEN(32), .EN_M(0)) u_m0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir0),
      .inst(inst), .pc_i(pc_i),
      .out_valid(ov0), .out_ready(out_ready),
      .pc_o(pc0), .inst_decode(dec0), .imm_out(imm0),
      .rd1(r1_0), .rd2(r2_0), .wr(w0), .illegal(il0));

   risc_v_id_stage #(.XLEN(32), .EN_M(1)) u_m1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir1),
      .inst(inst), .pc_i(pc_i),
      .out_valid(ov1), .out_ready(out_ready),
      .pc_o(pc1), .inst_decode(dec1), .imm_out(imm1),
      .rd1(r1_1), .rd2(r2_1), .wr(w1), .illegal(il1));

   always #5 clk = ~clk;

   function automatic logic [31:0] mask_of(int k);
      if (k <= 2)  return 32'h0000007F;
      if (k <= 23) return 32'h0000707F;
      return 32'hFE00707F;
   endfunction

   function automatic int ref_idx(logic [31:0] i, bit en);
      for (int k = 0; k < (en ? 45 : 37); k++)
         if ((i & mask_of(k)) == MT[k]) return k;
      return -1;
   endfunction

   function automatic logic [31:0] ref_imm(logic [31:0] i, int k);
      logic signed [11:0] v12;
      logic signed [12:0] v13;
      logic signed [20:0] v21;
      if (k == 0 || k == 1) return {i[31:12], 12'h000};
      if (k == 2) begin
         v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
         return 32'(v21);
      end
      if (k == 3 || (k >= 10 && k <= 14) || (k >= 18 && k <= 23)) begin
         v12 = i[31:20];
         return 32'(v12);
      end
      if (k >= 4 && k <= 9) begin
         v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
         return 32'(v13);
      end
      if (k >= 15 && k <= 17) begin
         v12 = {i[31:25], i[11:7]};
         return 32'(v12);
      end
      if (k >= 24 && k <= 26) return {27'd0, i[24:20]};
      return 32'd0;
   endfunction

   function automatic logic [31:0] gen_inst();
      int k;
      if ($urandom_range(0, 9) == 0) return $urandom;
      k = $urandom_range(0, 44);
      return MT[k] | ($urandom & ~mask_of(k));
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(string n, bit en, logic ov, logic ir,
                          logic [31:0] pc, logic [44:0] dec,
                          logic [31:0] imm, logic [4:0] r1,
                          logic [4:0] r2, logic [4:0] w, logic il);
      int k;
      chk({n, ".out_valid"}, ov, q.size() > 0);
      chk({n, ".in_ready"}, ir, q.size() < 2);
      if (q.size() > 0) begin
         k = ref_idx(q[0].inst, en);
         chk({n, ".pc_o"}, pc, q[0].pc);
         chk({n, ".decode"}, dec, (k < 0) ? 45'd0 : (45'd1 << k));
         chk({n, ".imm"}, imm, ref_imm(q[0].inst, k));
         chk({n, ".rd1"}, r1, q[0].inst[19:15]);
         chk({n, ".rd2"}, r2, q[0].inst[24:20]);
         chk({n, ".wr"}, w, q[0].inst[11:7]);
         chk({n, ".illegal"}, il, k < 0);
      end
   endtask

   task automatic chk_all();
      chk_dut("m0", 1'b0, ov0, ir0, pc0, {8'd0, dec0}, imm0,
              r1_0, r2_0, w0, il0);
      chk_dut("m1", 1'b1, ov1, ir1, pc1, dec1, imm1,
              r1_1, r2_1, w1, il1);
   endtask

   task automatic chk_zero(string n, logic ov, logic ir, logic [31:0] pc,
                           logic [44:0] dec, logic [31:0] imm,
                           logic [4:0] r1, logic [4:0] r2,
                           logic [4:0] w, logic il);
      chk({n, ".rst_ov"}, ov, 1'b0);
      chk({n, ".rst_ir"}, ir, 1'b1);
      chk({n, ".rst_pc"}, pc, 32'd0);
      chk({n, ".rst_dec"}, dec, 45'd0);
      chk({n, ".rst_imm"}, imm, 32'd0);
      chk({n, ".rst_regs"}, {r1, r2, w}, 15'd0);
      chk({n, ".rst_ill"}, il, 1'b0);
   endtask

   task automatic chk_reset();
      chk_zero("m0", ov0, ir0, pc0, {8'd0, dec0}, imm0, r1_0, r2_0, w0, il0);
      chk_zero("m1", ov1, ir1, pc1, dec1, imm1, r1_1, r2_1, w1, il1);
   endtask

   task automatic drive(logic v, logic [31:0] i, logic [31:0] p,
                        logic ordy, logic fl);
      in_valid  = v;
      inst      = i;
      pc_i      = p;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Model: queue of accepted entries, capacity two.
   task automatic tick();
      bit acc;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         acc = in_valid && (q.size() < 2);
         if (out_ready && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back('{inst: inst, pc: pc_i});
      end
      #1;
      chk_all();
   endtask

   initial begin
      logic [31:0] pc_r;
      rst = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #13;
      chk_reset();
      rst = 1'b0;

      drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
      tick();
      chk("addi.bit18", dec0[18], 1'b1);
      chk("addi.imm", imm0, 32'hFFFFFFFF);
      chk("addi.wr", w0, 5'd1);
      chk("addi.pc", pc0, 32'h100);
      drive(1'b1, 32'hFE208EE3, 32'h200, 1'b1, 1'b0);
      tick();
      chk("beq.bit4", dec0[4], 1'b1);
      chk("beq.imm", imm0, 32'hFFFFFFFC);
      drive(1'b1, 32'h008100E7, 32'h204, 1'b1, 1'b0);
      tick();
      chk("jalr.valid", ov0, 1'b1);
      chk("jalr.bit3", dec0[3], 1'b1);
      chk("jalr.imm", imm0, 32'h8);
      chk("jalr.rd1", r1_0, 5'd2);
      drive(1'b1, 32'h022081B3, 32'h300, 1'b1, 1'b0);
      tick();
      chk("mul.m0_ill", il0, 1'b1);
      chk("mul.m0_dec", dec0, 37'd0);
      chk("mul.m1_bit37", dec1[37], 1'b1);
      chk("mul.m1_wr", w1, 5'd3);
      chk("mul.m1_imm", imm1, 32'd0);
      drive(1'b1, 32'h0000000F, 32'h304, 1'b1, 1'b0);
      tick();
      chk("fence.m0_ill", il0, 1'b1);
      chk("fence.m1_ill", il1, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      tick();

      drive(1'b1, 32'h00A00113, 32'h400, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h002081B3, 32'h404, 1'b0, 1'b0);
      tick();
      chk("stall.in_ready", ir0, 1'b0);
      drive(1'b1, 32'h00312023, 32'h408, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b1, 32'h00312023, 32'h408, 1'b1, 1'b0);
      tick();
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      tick();
      tick();

      drive(1'b1, 32'h00500293, 32'h500, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h40628333, 32'h504, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h0000006F, 32'h508, 1'b0, 1'b1);
      tick();
      chk("flush.ov", ov0, 1'b0);
      chk("flush.ir", ir1, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      tick();
      tick();

      pc_r = 32'h1000;
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, gen_inst(), pc_r,
               $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
         pc_r += 4;
         tick();
      end

      drive(1'b1, 32'h00C00393, 32'h600, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h00A3A023, 32'h604, 1'b0, 1'b0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      chk_reset();
      #2;
      rst = 1'b0;
      drive(1'b1, 32'h00000117, 32'h700, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
